clk_enable_gen: RTL

Multi-channel clock-enable generator placed directly after the board PLL wrapper. It turns the single PLL output clock into NCH programmable-rate single-cycle enable strobes, using one phase accumulator per channel (e.g. 50 MHz clock → 25 MHz video, 1 MHz timer). It also filters the PLL lock signal and sequences the downstream system reset. Rates are runtime-reprogrammable, so new clock domains no longer need extra PLL outputs.

---
 rtl/clk_enable_gen_pkg.sv | 21 ++
 rtl/clk_enable_gen_lock_filter.sv | 92 +++++++++
 rtl/clk_enable_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/clk_enable_gen_pkg.sv
// Shared types and defaults for the clock-enable generator.
package clk_enable_gen_pkg;

    // Lock sequencing states.
    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } lock_state_t;

    localparam int NCH_MAX       = 16;
    localparam int DEF_NCH       = 3;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_LOCK_WAIT = 1024;

    // Width of the channel select; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_enable_gen_lock_filter.sv
// PLL lock filter: 2-flop synchroniser, lock-wait counter and reset sequencer.
// Outputs are registered from the next state, so the state change and the
// output change share one edge.
module lock_filter
    import clk_enable_gen_pkg::*;
#(
    parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pll_locked,
    output logic        sys_reset,
    output logic        lock_ok,
    output logic        lost_lock,
    output logic        run_next,
    output lock_state_t state
);

    localparam int CNT_W = $clog2(LOCK_WAIT + 1);

    logic             sync1;
    logic             lk;
    logic [CNT_W-1:0] cnt;
    lock_state_t      next_state;
    logic [CNT_W-1:0] next_cnt;

    // Bring the asynchronous PLL lock into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

    // Next-state and counter logic: any low lk outside RUN restarts the wait.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            WAIT: begin
                if (lk) begin
                    next_state = COUNT;
                    next_cnt   = CNT_W'(1);
                end else begin
                    next_cnt   = '0;
                end
            end
            COUNT: begin
                if (!lk) begin
                    next_state = WAIT;
                    next_cnt   = '0;
                end else if (cnt == CNT_W'(LOCK_WAIT)) begin
                    next_state = RUN;
                    next_cnt   = '0;
                end else begin
                    next_cnt   = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                next_cnt = '0;
                if (!lk) next_state = WAIT;
            end
            default: begin
                next_state = WAIT;
                next_cnt   = '0;
            end
        endcase
    end

    assign run_next = (next_state == RUN);

    // State, counter and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT;
            cnt       <= '0;
            sys_reset <= 1'b1;
            lock_ok   <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            sys_reset <= (next_state != RUN);
            lock_ok   <= (next_state == RUN);
            if (state == RUN && !lk) lost_lock <= 1'b1;
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: one phase accumulator per channel,
// each producing a registered single-cycle strobe from its carry-out.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int               NCH         = DEF_NCH,
    parameter int               ACC_W       = DEF_ACC_W,
    parameter int               LOCK_WAIT   = DEF_LOCK_WAIT,
    parameter logic [ACC_W-1:0] INC_DEFAULT = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ch_w(NCH)-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]       cfg_inc,
    input  logic                   resync,
    output logic [NCH-1:0]         ce,
    output logic                   sys_reset,
    output logic                   lock_ok,
    output logic                   lost_lock
);

    localparam int CH_W = ch_w(NCH);

    if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
        $error("clk_enable_gen: NCH out of range");
    end

    logic             run_next;
    lock_state_t      lock_state;
    logic             acc_en;
    logic             stg_valid;
    logic [CH_W-1:0]  stg_ch;
    logic [ACC_W-1:0] stg_inc;

    lock_filter #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_filter (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .sys_reset  (sys_reset),
        .lock_ok    (lock_ok),
        .lost_lock  (lost_lock),
        .run_next   (run_next),
        .state      (lock_state)
    );

    // Accumulate only while in RUN and staying there, so ce drops on the
    // same edge that leaves RUN.
    assign acc_en = (lock_state == RUN) && run_next;

    // Valid/ready: a request transfers on the edge where cfg_valid and
    // cfg_ready are both high; the staged write is applied on the next edge,
    // during which cfg_ready is low.
    assign cfg_ready = !stg_valid;

    // Config staging register (accept edge, then apply edge).
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_valid <= 1'b0;
            stg_ch    <= '0;
            stg_inc   <= '0;
        end else if (cfg_valid && !stg_valid) begin
            stg_valid <= 1'b1;
            stg_ch    <= cfg_ch;
            stg_inc   <= cfg_inc;
        end else begin
            stg_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] inc;
        logic [ACC_W:0]   sum;
        logic             hit;
        logic             ce_r;

        // Out-of-range channel selects match no channel and are dropped.
        assign hit = stg_valid && (stg_ch == CH_W'(i));
        assign sum = {1'b0, acc} + {1'b0, inc};
        assign ce[i] = ce_r;

        // Phase accumulator; the carry-out becomes the strobe.
        always_ff @(posedge clock) begin
            if (reset) begin
                acc  <= '0;
                inc  <= INC_DEFAULT;
                ce_r <= 1'b0;
            end else begin
                if (hit) inc <= stg_inc;
                if (!acc_en || resync || hit) begin
                    acc  <= '0;
                    ce_r <= 1'b0;
                end else begin
                    acc  <= sum[ACC_W-1:0];
                    ce_r <= sum[ACC_W];
                end
            end
        end
    end

endmodule
